dsp_mem_write_arbiter: RTL and testbench

Shares the write port of Data Memory Bank II between the DSP core's memory stage and a host/DMA sample loader. DSP writes have absolute priority and pass through with zero latency. DMA writes are buffered in a small FIFO and drained on cycles where the DSP is not writing. If the FIFO stays full while the DSP keeps writing, the block asserts `dsp_hold` for one cycle to freeze the core's gated clock and force a drain. Sits between the DSP top level (`write_addr_2` / `write_data_2` / `write_en_2`) and the bank II SRAM.

---
 rtl/dsp_mem_write_arbiter_pkg.sv | 15 +
 rtl/dsp_mem_write_arbiter_sync_fifo.sv | 44 ++++
 rtl/dsp_mem_write_arbiter.sv | 97 +++++++++
 tb/tb_dsp_mem_write_arbiter.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_mem_write_arbiter_pkg.sv
// Shared widths, defaults and state encodings for the bank II write arbiter.
// Widths mirror the SRAM/register length definitions of the DSP core.
package dsp_mem_write_arbiter_pkg;

    localparam int SRAM_ADDR_LEN  = 16;
    localparam int REG_WORD_LEN   = 16;
    localparam int ARB_DEPTH      = 4;
    localparam int ARB_STARVE_MAX = 16;

    typedef enum logic {
        ARB_RUN  = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dsp_mem_write_arbiter_sync_fifo.sv
// Circular-buffer FIFO holding {addr, data} DMA words for bank II.
// Pointers wrap naturally because DEPTH is a power of two.
module dsp_mem_write_arbiter_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_word,
    output logic [WIDTH-1:0] head,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr_word;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/dsp_mem_write_arbiter.sv
// Bank II write-port arbiter: DSP writes pass straight through, DMA words
// queue in a FIFO and drain on idle cycles; a one-cycle hold breaks starvation.
module dsp_mem_write_arbiter
    import dsp_mem_write_arbiter_pkg::*;
#(
    parameter int ADDR_W     = SRAM_ADDR_LEN,
    parameter int DATA_W     = REG_WORD_LEN,
    parameter int DEPTH      = ARB_DEPTH,
    parameter int STARVE_MAX = ARB_STARVE_MAX,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] dsp_write_addr,
    input  logic [DATA_W-1:0] dsp_write_data,
    input  logic              dsp_write_en,
    input  logic              dma_valid,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_data,
    output logic              dma_ready,
    output logic [ADDR_W-1:0] sram_write_addr,
    output logic [DATA_W-1:0] sram_write_data,
    output logic              sram_write_en,
    output logic              dsp_hold,
    output logic [CW-1:0]     fifo_count
);

    localparam int SW = $clog2(STARVE_MAX) + 1;
    localparam int WW = ADDR_W + DATA_W;

    arb_state_e      state_q;
    arb_state_e      state_d;
    logic [SW-1:0]   starve_q;
    logic [SW-1:0]   starve_d;
    logic [WW-1:0]   head;
    logic            push;
    logic            pop;
    logic            dsp_sel;
    logic            fifo_empty;
    logic            blocked;

    assign fifo_empty = (fifo_count == '0);
    assign dma_ready  = !rst && (fifo_count < CW'(DEPTH));
    assign push       = dma_valid && dma_ready;
    assign blocked    = (fifo_count == CW'(DEPTH)) && dsp_write_en;

    // During a hold the DSP write is dropped; the frozen pipeline replays it.
    assign dsp_hold = (state_q == ARB_HOLD);
    assign dsp_sel  = !dsp_hold && dsp_write_en;
    assign pop      = !rst && !dsp_sel && !fifo_empty;

    assign sram_write_en   = !rst && (dsp_sel || !fifo_empty);
    assign sram_write_addr = dsp_sel ? dsp_write_addr : head[WW-1:DATA_W];
    assign sram_write_data = dsp_sel ? dsp_write_data : head[DATA_W-1:0];

    dsp_mem_write_arbiter_sync_fifo #(
        .WIDTH (WW),
        .DEPTH (DEPTH)
    ) u_sync_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .wr_word ({dma_addr, dma_data}),
        .head    (head),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_RUN;
            starve_q <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        case (state_q)
            ARB_RUN: begin
                if (!blocked) begin
                    starve_d = '0;
                end else if (starve_q == SW'(STARVE_MAX - 1)) begin
                    state_d  = ARB_HOLD;
                    starve_d = '0;
                end else begin
                    starve_d = starve_q + 1'b1;
                end
            end
            ARB_HOLD: state_d = ARB_RUN;
        endcase
    end

endmodule

// File: tb/tb_dsp_mem_write_arbiter.sv
// Self-checking bench for dsp_mem_write_arbiter: directed scenarios plus
// randomized traffic compared against a queue-based reference model.
module tb_dsp_mem_write_arbiter;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int SMAX  = 16;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          rst;
    logic [AW-1:0] dsp_write_addr;
    logic [DW-1:0] dsp_write_data;
    logic          dsp_write_en;
    logic          dma_valid;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_data;
    logic          dma_ready;
    logic [AW-1:0] sram_write_addr;
    logic [DW-1:0] sram_write_data;
    logic          sram_write_en;
    logic          dsp_hold;
    logic [CW-1:0] fifo_count;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [AW+DW-1:0] mq[$];
    bit               m_hold;
    int               m_starve;
    bit               e_en;
    bit               e_ready;
    bit               e_pop;
    logic [AW-1:0]    e_addr;
    logic [DW-1:0]    e_data;

    dsp_mem_write_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .DEPTH      (DEPTH),
        .STARVE_MAX (SMAX)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .dsp_write_addr  (dsp_write_addr),
        .dsp_write_data  (dsp_write_data),
        .dsp_write_en    (dsp_write_en),
        .dma_valid       (dma_valid),
        .dma_addr        (dma_addr),
        .dma_data        (dma_data),
        .dma_ready       (dma_ready),
        .sram_write_addr (sram_write_addr),
        .sram_write_data (sram_write_data),
        .sram_write_en   (sram_write_en),
        .dsp_hold        (dsp_hold),
        .fifo_count      (fifo_count)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_eval();
        bit sel;
        sel     = !m_hold && dsp_write_en;
        e_ready = !rst && (mq.size() < DEPTH);
        e_pop   = !rst && !sel && (mq.size() > 0);
        e_en    = !rst && (sel || mq.size() > 0);
        if (sel) begin
            e_addr = dsp_write_addr;
            e_data = dsp_write_data;
        end else if (mq.size() > 0) begin
            {e_addr, e_data} = mq[0];
        end else begin
            e_addr = '0;
            e_data = '0;
        end
    endtask

    task automatic tick();
        bit               blk;
        bit               push;
        logic [AW+DW-1:0] w;
        model_eval();
        blk  = (mq.size() == DEPTH) && dsp_write_en;
        push = dma_valid && e_ready;
        w    = {dma_addr, dma_data};
        @(posedge clk);
        #1;
        if (rst) begin
            mq.delete();
            m_hold   = 0;
            m_starve = 0;
        end else begin
            if (e_pop) void'(mq.pop_front());
            if (push) mq.push_back(w);
            if (m_hold) begin
                m_hold   = 0;
                m_starve = 0;
            end else if (blk) begin
                m_starve++;
                if (m_starve == SMAX) begin
                    m_hold   = 1;
                    m_starve = 0;
                end
            end else begin
                m_starve = 0;
            end
        end
    endtask

    task automatic drive(input bit r, input bit den, input logic [AW-1:0] da,
                         input logic [DW-1:0] dd, input bit dv,
                         input logic [AW-1:0] va, input logic [DW-1:0] vd);
        rst            = r;
        dsp_write_en   = den;
        dsp_write_addr = da;
        dsp_write_data = dd;
        dma_valid      = dv;
        dma_addr       = va;
        dma_data       = vd;
        #2;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        n_checks++;
        if (dma_ready !== 1'b0)
            $display("FAIL rst_ready: got %b want 0", dma_ready);
        else n_pass++;
        n_checks++;
        if (sram_write_en !== 1'b0)
            $display("FAIL rst_en: got %b want 0", sram_write_en);
        else n_pass++;
        n_checks++;
        if (fifo_count !== 3'd0 || dsp_hold !== 1'b0)
            $display("FAIL rst_state: got count=%0d hold=%b want 0/0",
                     fifo_count, dsp_hold);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (dma_ready !== 1'b1)
            $display("FAIL rst_release_ready: got %b want 1", dma_ready);
        else n_pass++;
    endtask

    task automatic test_dma_basic();
        drive(0, 0, 0, 0, 1, 16'h0010, 16'hAAAA);
        n_checks++;
        if (sram_write_en !== 1'b0 || fifo_count !== 3'd0)
            $display("FAIL basic_idle: got en=%b count=%0d want 0/0",
                     sram_write_en, fifo_count);
        else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (sram_write_en !== 1'b1 || sram_write_addr !== 16'h0010 ||
            sram_write_data !== 16'hAAAA || fifo_count !== 3'd1)
            $display("FAIL basic_write: got en=%b %h/%h count=%0d want 1 0010/aaaa 1",
                     sram_write_en, sram_write_addr, sram_write_data, fifo_count);
        else n_pass++;
        tick();
        n_checks++;
        if (fifo_count !== 3'd0 || sram_write_en !== 1'b0)
            $display("FAIL basic_drained: got count=%0d en=%b want 0/0",
                     fifo_count, sram_write_en);
        else n_pass++;
    endtask

    task automatic test_dsp_priority();
        drive(0, 0, 0, 0, 1, 16'h0020, 16'h1234);
        tick();
        drive(0, 1, 16'h0003, 16'h5555, 0, 0, 0);
        n_checks++;
        if (sram_write_en !== 1'b1 || sram_write_addr !== 16'h0003 ||
            sram_write_data !== 16'h5555 || fifo_count !== 3'd1)
            $display("FAIL prio_dsp: got en=%b %h/%h count=%0d want 1 0003/5555 1",
                     sram_write_en, sram_write_addr, sram_write_data, fifo_count);
        else n_pass++;
        tick();
        drive(0, 1, 16'h0004, 16'h6666, 0, 0, 0);
        n_checks++;
        if (sram_write_addr !== 16'h0004 || fifo_count !== 3'd1)
            $display("FAIL prio_dsp2: got %h count=%0d want 0004 1",
                     sram_write_addr, fifo_count);
        else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (sram_write_en !== 1'b1 || sram_write_addr !== 16'h0020 ||
            sram_write_data !== 16'h1234)
            $display("FAIL prio_dma_after: got en=%b %h/%h want 1 0020/1234",
                     sram_write_en, sram_write_addr, sram_write_data);
        else n_pass++;
        tick();
        n_checks++;
        if (fifo_count !== 3'd0)
            $display("FAIL prio_drained: got %0d want 0", fifo_count);
        else n_pass++;
    endtask

    task automatic test_starve_hold();
        int bad_hold;
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 16'h0003, 16'h1111, 1, 16'h0040 + 16'(i), 16'hB000 + 16'(i));
            tick();
        end
        drive(0, 1, 16'h0003, 16'h1111, 0, 0, 0);
        n_checks++;
        if (dma_ready !== 1'b0 || fifo_count !== 3'd4)
            $display("FAIL starve_full: got ready=%b count=%0d want 0/4",
                     dma_ready, fifo_count);
        else n_pass++;
        bad_hold = 0;
        for (int c = 0; c < SMAX; c++) begin
            drive(0, 1, 16'h0003, 16'h1111, 0, 0, 0);
            if (dsp_hold !== 1'b0 || sram_write_addr !== 16'h0003 ||
                fifo_count !== 3'd4)
                bad_hold++;
            tick();
        end
        n_checks++;
        if (bad_hold != 0)
            $display("FAIL starve_blocked: got %0d bad cycles want 0", bad_hold);
        else n_pass++;
        drive(0, 1, 16'h0003, 16'h1111, 0, 0, 0);
        n_checks++;
        if (dsp_hold !== 1'b1 || sram_write_en !== 1'b1 ||
            sram_write_addr !== 16'h0040 || sram_write_data !== 16'hB000)
            $display("FAIL starve_hold: got hold=%b en=%b %h/%h want 1 1 0040/b000",
                     dsp_hold, sram_write_en, sram_write_addr, sram_write_data);
        else n_pass++;
        tick();
        n_checks++;
        if (dsp_hold !== 1'b0 || fifo_count !== 3'd3 ||
            sram_write_addr !== 16'h0003)
            $display("FAIL starve_release: got hold=%b count=%0d addr=%h want 0 3 0003",
                     dsp_hold, fifo_count, sram_write_addr);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        tick();
        n_checks++;
        if (fifo_count !== 3'd0)
            $display("FAIL starve_drain: got %0d want 0", fifo_count);
        else n_pass++;
    endtask

    task automatic test_push_pop();
        int bad_cnt;
        int bad_ord;
        drive(0, 1, 16'h0007, 16'h0, 1, 16'h0050, 16'hC000);
        tick();
        drive(0, 1, 16'h0007, 16'h0, 1, 16'h0051, 16'hC001);
        tick();
        bad_cnt = 0;
        bad_ord = 0;
        for (int j = 0; j < 8; j++) begin
            drive(0, 0, 0, 0, 1, 16'h0052 + 16'(j), 16'hC002 + 16'(j));
            if (fifo_count !== 3'd2) bad_cnt++;
            if (sram_write_en !== 1'b1 || sram_write_data !== 16'hC000 + 16'(j))
                bad_ord++;
            tick();
        end
        n_checks++;
        if (bad_cnt != 0)
            $display("FAIL pp_count: got %0d cycles off count 2 want 0", bad_cnt);
        else n_pass++;
        for (int j = 8; j < 10; j++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            if (sram_write_data !== 16'hC000 + 16'(j)) bad_ord++;
            tick();
        end
        n_checks++;
        if (bad_ord != 0)
            $display("FAIL pp_order: got %0d out-of-order words want 0", bad_ord);
        else n_pass++;
        n_checks++;
        if (fifo_count !== 3'd0)
            $display("FAIL pp_drained: got %0d want 0", fifo_count);
        else n_pass++;
    endtask

    task automatic test_reset_mid_hold();
        for (int i = 0; i < 4; i++) begin
            drive(0, 1, 16'h0009, 16'h2222, 1, 16'h0060 + 16'(i), 16'hD000 + 16'(i));
            tick();
        end
        for (int c = 0; c < SMAX; c++) begin
            drive(0, 1, 16'h0009, 16'h2222, 0, 0, 0);
            tick();
        end
        drive(0, 1, 16'h0009, 16'h2222, 0, 0, 0);
        n_checks++;
        if (dsp_hold !== 1'b1)
            $display("FAIL mid_hold_reached: got %b want 1", dsp_hold);
        else n_pass++;
        drive(1, 1, 16'h0009, 16'h2222, 1, 16'h0070, 16'hE000);
        n_checks++;
        if (dma_ready !== 1'b0 || sram_write_en !== 1'b0)
            $display("FAIL mid_rst_during: got ready=%b en=%b want 0/0",
                     dma_ready, sram_write_en);
        else n_pass++;
        tick();
        n_checks++;
        if (fifo_count !== 3'd0 || dsp_hold !== 1'b0 ||
            sram_write_en !== 1'b0 || dma_ready !== 1'b0)
            $display("FAIL mid_rst_after_edge: got count=%0d hold=%b en=%b ready=%b want 0 0 0 0",
                     fifo_count, dsp_hold, sram_write_en, dma_ready);
        else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (dma_ready !== 1'b1 || sram_write_en !== 1'b0)
            $display("FAIL mid_rst_release: got ready=%b en=%b want 1/0",
                     dma_ready, sram_write_en);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        int holds;
        int prob;
        holds = 0;
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        for (int cyc = 0; cyc < 600; cyc++) begin
            case ((cyc / 60) % 3)
                0:       prob = 97;
                1:       prob = 50;
                default: prob = 10;
            endcase
            drive($urandom_range(0, 199) == 0,
                  $urandom_range(0, 99) < prob,
                  16'($urandom), 16'($urandom),
                  $urandom_range(0, 99) < 60,
                  16'($urandom), 16'($urandom));
            model_eval();
            if (m_hold) holds++;
            n_checks++;
            if (sram_write_en !== e_en)
                $display("FAIL rnd_en cyc=%0d: got %b want %b", cyc, sram_write_en, e_en);
            else n_pass++;
            if (e_en) begin
                n_checks++;
                if (sram_write_addr !== e_addr || sram_write_data !== e_data)
                    $display("FAIL rnd_word cyc=%0d: got %h/%h want %h/%h", cyc,
                             sram_write_addr, sram_write_data, e_addr, e_data);
                else n_pass++;
            end
            n_checks++;
            if (dma_ready !== e_ready)
                $display("FAIL rnd_ready cyc=%0d: got %b want %b", cyc, dma_ready, e_ready);
            else n_pass++;
            n_checks++;
            if (fifo_count !== CW'(mq.size()))
                $display("FAIL rnd_count cyc=%0d: got %0d want %0d", cyc,
                         fifo_count, mq.size());
            else n_pass++;
            n_checks++;
            if (dsp_hold !== m_hold)
                $display("FAIL rnd_hold cyc=%0d: got %b want %b", cyc, dsp_hold, m_hold);
            else n_pass++;
            tick();
        end
        $display("random phase: %0d hold cycles seen", holds);
    endtask

    initial begin
        rst            = 1;
        dsp_write_en   = 0;
        dsp_write_addr = '0;
        dsp_write_data = '0;
        dma_valid      = 0;
        dma_addr       = '0;
        dma_data       = '0;
        mq.delete();
        m_hold   = 0;
        m_starve = 0;
        @(posedge clk);
        #1;
        test_reset();
        test_dma_basic();
        test_dsp_priority();
        test_starve_hold();
        test_push_pop();
        test_reset_mid_hold();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
